mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multi-cycle main control FSM for the 32-bit MIPS core. It sequences the shared datapath (PC/IR registers, register file, Execute-stage ALU with its ALUSrc/ALUOp controls, unified memory port) through fetch, decode, execute, memory and writeback steps. It owns the memory request handshake and keeps a retired-instruction counter. It sits between the instruction register opcode field and every datapath control strobe.

## Interface
Parameters:
- none (opcode encodings fixed: R-type 6'h00, lw 6'h23, sw 6'h2B, beq 6'h04, j 6'h02, addi 6'h08)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes current MemRead/MemWrite this cycle
- stall  in  1  freeze FSM and suppress all write strobes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  0 = memory address from PC, 1 = from ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  latch instruction register
- MemtoReg  out  1  register write data from MDR (1) or ALUOut (0)
- RegDst  out  1  destination rd (1) or rt (0)
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
- ALUOp  out  2  00 add, 01 subtract, 10 decode funct
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  out  1  one-cycle pulse on undefined opcode
- instret  out  32  retired-instruction count

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, ILLEGAL.
- Unlisted outputs are 0 in every state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1 (Mealy-gated); -> DECODE on that cycle, else hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state: lw/sw -> MEM_ADDR; R-type -> R_EXEC; addi -> ADDI_EXEC; beq -> BRANCH; j -> JUMP; other -> ILLEGAL.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1; -> MEM_WB when mem_ready, else hold.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH, retire.
- MEM_WRITE: MemWrite=1, IorD=1; -> FETCH with retire when mem_ready, else hold.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH, retire.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0; -> FETCH, retire.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; -> FETCH, retire.
- JUMP: PCWrite=1, PCSource=10; -> FETCH, retire.
- ILLEGAL: illegal_op=1 for exactly one cycle; -> FETCH; no retire; PC already advanced by FETCH.
- Retire: instret += 1 on the clock edge leaving a retiring state; wraps 32'hFFFF_FFFF -> 0.
- stall=1: state and instret hold; PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite and illegal_op are forced 0.
  - MemRead, muxes and ALU controls keep their state values.
  - A mem_ready arriving while stall=1 is ignored; memory must re-assert it.
- stall has priority over mem_ready.

## Timing
- Reset (rst_n low, async): state=FETCH, instret=0. All outputs are forced 0 while rst_n=0, including MemRead.
- First MemRead is asserted the cycle after rst_n rises (synchronous release).
- Reset mid-instruction aborts immediately; no strobe completes after reset assertion.
- Zero-wait memory (mem_ready=1 whenever requested), cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3.
- Each memory wait cycle adds exactly one cycle in FETCH, MEM_READ or MEM_WRITE.
- Control outputs are combinational from registered state, plus mem_ready/stall gating. No output depends on opcode outside DECODE.

## Test plan
- Reset then R-type with mem_ready tied 1 -> states FETCH, DECODE, R_EXEC, R_WB; RegWrite=1, RegDst=1 in cycle 4; instret=1 after cycle 4.
- lw with mem_ready low 2 cycles in FETCH and 1 cycle in MEM_READ -> 8 total cycles; IRWrite pulses once, on the ready cycle; MemtoReg=1 in MEM_WB.
- beq then j back-to-back -> PCWriteCond=1, ALUOp=01 in cycle 3; PCWrite=1, PCSource=10 in cycle 6; instret=2.
- opcode 6'h3F -> illegal_op pulses for 1 cycle in cycle 3, FSM returns to FETCH, instret unchanged.
- sw with stall=1 for 2 cycles inside MEM_WRITE, with mem_ready=1 throughout -> MemWrite=0 during stall; completes on first unstalled cycle; instret +1 exactly once.
- rst_n pulled low in MEM_READ -> all outputs 0 immediately; instret=0; after release, FETCH with MemRead=1 on the next cycle. Preload instret to 32'hFFFF_FFFF via forced retire sequence -> wraps to 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Memory request handshake between the multi-cycle
// controller and the unified memory port.
interface mips_multicycle_ctrl_if;
   logic MemRead;
   logic MemWrite;
   logic IorD;
   logic mem_ready;

   modport master (
      output MemRead,
      output MemWrite,
      output IorD,
      input  mem_ready
   );

   modport slave (
      input  MemRead,
      input  MemWrite,
      input  IorD,
      output mem_ready
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with memory
// handshake and retired-instruction counter.
module mips_multicycle_ctrl (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [5:0]            opcode,
   input  logic                  stall,
   mips_multicycle_ctrl_if.master mem,
   output logic                  PCWrite,
   output logic                  PCWriteCond,
   output logic                  IRWrite,
   output logic                  MemtoReg,
   output logic                  RegDst,
   output logic                  RegWrite,
   output logic                  ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            ALUOp,
   output logic [1:0]            PCSource,
   output logic                  illegal_op,
   output logic [31:0]           instret
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADDR, MEM_READ,
      MEM_WB, MEM_WRITE, R_EXEC, R_WB,
      ADDI_EXEC, ADDI_WB, BRANCH, JUMP,
      ILLEGAL
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal;
   } ctrl_t;

   state_t      st;
   state_t      nxt;
   ctrl_t       c;
   ctrl_t       co;
   logic        run;
   logic        go;
   logic        retire;
   logic [31:0] instret_q;

   logic is_r, is_lw, is_sw;
   logic is_beq, is_j, is_addi;

   assign is_r    = (opcode == 6'h00);
   assign is_lw   = (opcode == 6'h23);
   assign is_sw   = (opcode == 6'h2B);
   assign is_beq  = (opcode == 6'h04);
   assign is_j    = (opcode == 6'h02);
   assign is_addi = (opcode == 6'h08);

   // run gives a one-cycle quiet period after reset release
   assign go = run & ~stall;

   // Next state, raw control levels and retire detection
   always_comb begin
      nxt    = st;
      retire = 1'b0;
      c      = '0;
      unique case (st)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
            if (mem.mem_ready) begin
               c.ir_write = 1'b1;
               c.pc_write = 1'b1;
               nxt        = DECODE;
            end
         end
         DECODE: begin
            c.alu_src_b = 2'b11;
            unique case (1'b1)
               is_lw | is_sw: nxt = MEM_ADDR;
               is_r:          nxt = R_EXEC;
               is_addi:       nxt = ADDI_EXEC;
               is_beq:        nxt = BRANCH;
               is_j:          nxt = JUMP;
               default:       nxt = ILLEGAL;
            endcase
         end
         MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            nxt = is_sw ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
            if (mem.mem_ready) nxt = MEM_WB;
         end
         MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            nxt          = FETCH;
            retire       = 1'b1;
         end
         MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
            if (mem.mem_ready) begin
               nxt    = FETCH;
               retire = 1'b1;
            end
         end
         R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
            nxt         = R_WB;
         end
         R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            nxt         = FETCH;
            retire      = 1'b1;
         end
         ADDI_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            nxt         = ADDI_WB;
         end
         ADDI_WB: begin
            c.reg_write = 1'b1;
            nxt         = FETCH;
            retire      = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
            nxt             = FETCH;
            retire          = 1'b1;
         end
         JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
            nxt         = FETCH;
            retire      = 1'b1;
         end
         ILLEGAL: begin
            c.illegal = 1'b1;
            nxt       = FETCH;
         end
         default: nxt = FETCH;
      endcase
      // stall freezes progress and kills every write strobe
      if (!go) begin
         nxt    = st;
         retire = 1'b0;
      end
      if (stall) begin
         c.pc_write      = 1'b0;
         c.pc_write_cond = 1'b0;
         c.ir_write      = 1'b0;
         c.reg_write     = 1'b0;
         c.mem_write     = 1'b0;
         c.illegal       = 1'b0;
      end
   end

   // Outputs silent during reset and the release cycle
   always_comb begin
      co = '0;
      if (run && rst_n) co = c;
   end

   assign PCWrite      = co.pc_write;
   assign PCWriteCond  = co.pc_write_cond;
   assign mem.IorD     = co.iord;
   assign mem.MemRead  = co.mem_read;
   assign mem.MemWrite = co.mem_write;
   assign IRWrite      = co.ir_write;
   assign MemtoReg     = co.mem_to_reg;
   assign RegDst       = co.reg_dst;
   assign RegWrite     = co.reg_write;
   assign ALUSrcA      = co.alu_src_a;
   assign ALUSrcB      = co.alu_src_b;
   assign ALUOp        = co.alu_op;
   assign PCSource     = co.pc_source;
   assign illegal_op   = co.illegal;
   assign instret      = instret_q;

   // State, release flag and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= FETCH;
         run       <= 1'b0;
         instret_q <= '0;
      end else begin
         st  <= nxt;
         run <= 1'b1;
         if (retire) instret_q <= instret_q + 32'd1;
      end
   end

endmodule
